// File: rtl/m68k_region_decoder_pkg.sv
// m68k_region_decoder_pkg: shared types, widths and per-PCB region tables for the 68000 region decoder
package m68k_region_decoder_pkg;
  localparam int ADDR_W = 24;
  localparam int WAIT_W = 4;
  typedef enum logic [1:0] {MODE_RW, MODE_RD, MODE_WR, MODE_OFF} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_NOMAP, S_BERR} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;
    logic [WAIT_W-1:0] wait_st;
    mode_e             mode;
    logic              ext;
  } region_cfg_t;
  localparam region_cfg_t CFG_OFF = '{base: '0, mask: '0, wait_st: '0, mode: MODE_OFF, ext: 1'b0};
  localparam region_cfg_t pcb_A7007_A8007 [5] = '{
    '{base: 24'h000000, mask: 24'hFC0000, wait_st: 4'd0, mode: MODE_RD, ext: 1'b0},
    '{base: 24'h040000, mask: 24'hFFC000, wait_st: 4'd0, mode: MODE_RW, ext: 1'b0},
    '{base: 24'h080000, mask: 24'hFF8000, wait_st: 4'd1, mode: MODE_RW, ext: 1'b0},
    '{base: 24'h0C0000, mask: 24'hFF0000, wait_st: 4'd2, mode: MODE_RW, ext: 1'b0},
    '{base: 24'h100000, mask: 24'hF00000, wait_st: 4'd0, mode: MODE_RW, ext: 1'b1}
  };
  localparam region_cfg_t pcb_A7008 [4] = '{
    '{base: 24'h000000, mask: 24'hF80000, wait_st: 4'd0, mode: MODE_RD, ext: 1'b0},
    '{base: 24'h200000, mask: 24'hFF0000, wait_st: 4'd0, mode: MODE_RW, ext: 1'b0},
    '{base: 24'h400000, mask: 24'hFFC000, wait_st: 4'd3, mode: MODE_RW, ext: 1'b0},
    '{base: 24'h800000, mask: 24'hFFFF00, wait_st: 4'd4, mode: MODE_WR, ext: 1'b0}
  };
  function automatic logic mode_allows(mode_e m, logic rw);
    return m == MODE_RW || (m == MODE_RD && rw) || (m == MODE_WR && !rw);
  endfunction
endpackage

// File: rtl/m68k_region_decoder_if.sv
// m68k_region_decoder_if: CPU-side bus signals between the 68000 and the region decoder
interface m68k_region_decoder_if
  import m68k_region_decoder_pkg::*;
#(parameter int NUM_REGIONS = 16);
  localparam int IW = $clog2(NUM_REGIONS);
  logic [ADDR_W-1:0]      a;
  logic                   as_n;
  logic                   rw;
  logic                   ext_ready;
  logic [NUM_REGIONS-1:0] cs;
  logic [IW-1:0]          region_idx;
  logic                   hit;
  logic                   dtack_n;
  logic                   berr_n;
  modport master (output a, as_n, rw, ext_ready, input cs, region_idx, hit, dtack_n, berr_n);
  modport slave  (input a, as_n, rw, ext_ready, output cs, region_idx, hit, dtack_n, berr_n);
endinterface

// File: rtl/m68k_region_decoder_match.sv
// m68k_region_decoder_match: combinational priority matcher, lowest matching index wins
module m68k_region_decoder_match
  import m68k_region_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 16
) (
  input  region_cfg_t [NUM_REGIONS-1:0]  tbl_i,
  input  logic [ADDR_W-1:0]              a_i,
  input  logic                           rw_i,
  output logic                           hit_o,
  output logic [$clog2(NUM_REGIONS)-1:0] idx_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (((a_i ^ tbl_i[i].base) & tbl_i[i].mask) == '0 && mode_allows(tbl_i[i].mode, rw_i)) begin
        hit_o = 1'b1;
        idx_o = ($clog2(NUM_REGIONS))'(i);
      end
  end
endmodule

// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder: programmable 68000 chip-select decoder with wait states, DTACK and BERR watchdog
module m68k_region_decoder
  import m68k_region_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_we_i,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx_i,
  input  logic [ADDR_W-1:0]              cfg_base_i,
  input  logic [ADDR_W-1:0]              cfg_mask_i,
  input  logic [WAIT_W-1:0]              cfg_wait_i,
  input  logic [1:0]                     cfg_mode_i,
  input  logic                           cfg_ext_i,
  m68k_region_decoder_if.slave           bus
);
  localparam int IW = $clog2(NUM_REGIONS);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  region_cfg_t [NUM_REGIONS-1:0] tbl_q;
  state_e                        state_q;
  logic [IW-1:0]                 idx_q, m_idx;
  logic [NUM_REGIONS-1:0]        cs_q;
  logic [WAIT_W-1:0]             cnt_q;
  logic [WD_W-1:0]               wd_q;
  logic                          m_hit, ext_q, hit_q, dtack_q, berr_q;

  m68k_region_decoder_match #(.NUM_REGIONS(NUM_REGIONS)) u_match (
    .tbl_i (tbl_q),
    .a_i   (bus.a),
    .rw_i  (bus.rw),
    .hit_o (m_hit),
    .idx_o (m_idx)
  );

  // Table writes land at the edge, so a DECODE on the same edge still sees the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tbl_q   <= {NUM_REGIONS{CFG_OFF}};
      state_q <= S_IDLE;
      idx_q   <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      ext_q   <= 1'b0;
      hit_q   <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      if (cfg_we_i)
        tbl_q[cfg_idx_i] <= '{base: cfg_base_i, mask: cfg_mask_i, wait_st: cfg_wait_i,
                              mode: mode_e'(cfg_mode_i), ext: cfg_ext_i};
      if (bus.as_n && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
        cs_q    <= '0;
        hit_q   <= 1'b0;
        dtack_q <= 1'b1;
        berr_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (!bus.as_n) state_q <= S_DECODE;
          S_DECODE: begin
            wd_q <= WD_W'(1);
            if (m_hit) begin
              state_q <= S_WAIT;
              idx_q   <= m_idx;
              cnt_q   <= tbl_q[m_idx].wait_st;
              ext_q   <= tbl_q[m_idx].ext;
              cs_q    <= NUM_REGIONS'(1) << m_idx;
              hit_q   <= 1'b1;
            end else
              state_q <= S_NOMAP;
          end
          S_WAIT:
            if (ext_q ? bus.ext_ready : cnt_q == '0) begin
              state_q <= S_ACK;
              dtack_q <= 1'b0;
            end else if (wd_q == WD_MAX) begin
              state_q <= S_BERR;
              berr_q  <= 1'b0;
              cs_q    <= '0;
              hit_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - WAIT_W'(cnt_q != '0);
              wd_q  <= wd_q + WD_W'(1);
            end
          S_NOMAP:
            if (wd_q == WD_MAX) begin
              state_q <= S_BERR;
              berr_q  <= 1'b0;
            end else
              wd_q <= wd_q + WD_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign bus.cs         = cs_q;
  assign bus.region_idx = idx_q;
  assign bus.hit        = hit_q;
  assign bus.dtack_n    = dtack_q;
  assign bus.berr_n     = berr_q;
endmodule

// File: tb/tb_m68k_region_decoder.sv
// tb_m68k_region_decoder: directed table-driven bench for the region decoder
module tb_m68k_region_decoder;
  import m68k_region_decoder_pkg::*;
  localparam int TIMEOUT = 255;
  localparam int BL = TIMEOUT + 2;

  typedef struct {
    bit          bus;
    int          idx;
    logic [23:0] a;
    logic [23:0] mask;
    int          wt;
    mode_e       mode;
    bit          ext;
    bit          rw;
    bit          hit;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [23:0] cfg_base = '0;
  logic [23:0] cfg_mask = '0;
  logic [3:0]  cfg_wait = '0;
  logic [1:0]  cfg_mode = 2'b11;
  logic        cfg_ext = 1'b0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vt[$];

  m68k_region_decoder_if bus ();

  m68k_region_decoder #(.NUM_REGIONS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_base_i (cfg_base),
    .cfg_mask_i (cfg_mask),
    .cfg_wait_i (cfg_wait),
    .cfg_mode_i (cfg_mode),
    .cfg_ext_i  (cfg_ext),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t cv(int i, logic [23:0] b, logic [23:0] m, int w, mode_e md, bit e);
    cv = '{bus: 1'b0, idx: i, a: b, mask: m, wt: w, mode: md, ext: e, rw: 1'b0, hit: 1'b0, lat: 0};
  endfunction

  function automatic vec_t bv(logic [23:0] a, bit rw, bit h, int i, int l);
    bv = '{bus: 1'b1, idx: i, a: a, mask: '0, wt: 0, mode: MODE_OFF, ext: 1'b0, rw: rw, hit: h, lat: l};
  endfunction

  task automatic cfg_write(input int i, input logic [23:0] b, input logic [23:0] m, input int w,
                           input mode_e md, input bit e);
    cfg_idx = 4'(i); cfg_base = b; cfg_mask = m; cfg_wait = 4'(w); cfg_mode = md; cfg_ext = e;
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " cs"}, 32'(bus.cs), 0);
    chk({nm, " hit"}, 32'(bus.hit), 0);
    chk({nm, " dtack_n"}, 32'(bus.dtack_n), 1);
    chk({nm, " berr_n"}, 32'(bus.berr_n), 1);
  endtask

  // Drives one bus cycle and measures edges from as_n fall to DTACK/BERR.
  task automatic run_cycle(input logic [23:0] a, input bit rw, input bit eh, input int ei,
                           input int el, input int ext_at, input string nm);
    int  k;
    bit  done;
    logic [15:0] one;
    one = 16'h1;
    bus.a = a; bus.rw = rw; bus.ext_ready = (ext_at == 0); bus.as_n = 1'b0;
    k = 0; done = 1'b0;
    while (!done && k < BL + 20) begin
      @(posedge clk); #1; k++;
      if (k == ext_at) bus.ext_ready = 1'b1;
      chk({nm, " both_low"}, 32'(!bus.dtack_n && !bus.berr_n), 0);
      chk({nm, " onehot"}, 32'($onehot0(bus.cs)), 1);
      if (k == 2) begin
        chk({nm, " hit"}, 32'(bus.hit), 32'(eh));
        chk({nm, " cs"}, 32'(bus.cs), eh ? 32'(one << ei) : 0);
        chk({nm, " idx"}, 32'(bus.region_idx), eh ? 32'(ei) : 0);
      end
      done = !bus.dtack_n || !bus.berr_n;
    end
    chk({nm, " lat"}, 32'(k), 32'(el));
    chk({nm, " ack"}, 32'(!bus.dtack_n), 32'(el != BL));
    if (!bus.berr_n) chk({nm, " berr_cs"}, 32'(bus.cs), 0);
    bus.as_n = 1'b1; bus.ext_ready = 1'b0;
    @(posedge clk); #1;
    chk_idle({nm, " end"});
  endtask

  initial begin
    logic [15:0] one;
    int k;
    one = 16'h1;
    bus.a = '0; bus.rw = 1'b1; bus.as_n = 1'b1; bus.ext_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset idx", 32'(bus.region_idx), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    vt.push_back(bv(24'h000000, 1, 0, 0, BL));
    vt.push_back(cv(0, 24'h000000, 24'hFC0000, 0, MODE_RW, 0));
    vt.push_back(cv(2, 24'h040000, 24'hFFC000, 5, MODE_RW, 0));
    vt.push_back(bv(24'h012345, 1, 1, 0, 3));
    vt.push_back(bv(24'h041000, 0, 1, 2, 8));
    vt.push_back(bv(24'h043FFF, 1, 1, 2, 8));
    vt.push_back(bv(24'h03FFFF, 0, 1, 0, 3));
    vt.push_back(bv(24'h500000, 1, 0, 0, BL));
    vt.push_back(cv(0, 24'h080000, 24'hFF0000, 1, MODE_RW, 0));
    vt.push_back(cv(1, 24'h080000, 24'hF80000, 2, MODE_RD, 0));
    vt.push_back(bv(24'h080000, 0, 1, 0, 4));
    vt.push_back(bv(24'h080010, 1, 1, 0, 4));
    vt.push_back(bv(24'h0FFFFE, 1, 1, 1, 5));
    vt.push_back(bv(24'h0FFFFE, 0, 0, 0, BL));
    vt.push_back(cv(0, 24'h080000, 24'hFF0000, 1, MODE_WR, 0));
    vt.push_back(bv(24'h080010, 1, 1, 1, 5));
    vt.push_back(bv(24'h080010, 0, 1, 0, 4));
    vt.push_back(cv(3, 24'hC00000, 24'hFF0000, 7, MODE_RW, 1));
    vt.push_back(bv(24'hC01234, 1, 1, 3, 3));

    foreach (vt[i])
      if (vt[i].bus) run_cycle(vt[i].a, vt[i].rw, vt[i].hit, vt[i].idx, vt[i].lat, 0, $sformatf("vec%0d", i));
      else cfg_write(vt[i].idx, vt[i].a, vt[i].mask, vt[i].wt, vt[i].mode, vt[i].ext);

    // Rewrite entry 2 on the DECODE edge: this cycle keeps wait 5, the next one sees wait 1.
    bus.a = 24'h041000; bus.rw = 1'b1; bus.ext_ready = 1'b1; bus.as_n = 1'b0;
    @(posedge clk); #1;
    cfg_idx = 4'd2; cfg_base = 24'h040000; cfg_mask = 24'hFFC000; cfg_wait = 4'd1;
    cfg_mode = MODE_RW; cfg_ext = 1'b0; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("upd cs", 32'(bus.cs), 32'h4);
    k = 2;
    while (bus.dtack_n && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("upd old_lat", 32'(k), 8);
    bus.as_n = 1'b1;
    @(posedge clk); #1;
    run_cycle(24'h041000, 0, 1, 2, 4, 0, "upd_new");

    // Abort just before DTACK would assert.
    bus.a = 24'h041000; bus.rw = 1'b1; bus.as_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort hit", 32'(bus.hit), 1);
    chk("abort dtack_pre", 32'(bus.dtack_n), 1);
    bus.as_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("abort");

    run_cycle(24'hC01234, 0, 1, 3, 6, 5, "ext_late");
    run_cycle(24'hC01234, 1, 1, 3, BL, 99999, "ext_stuck");

    // Async reset in the middle of a wait-state cycle.
    bus.a = 24'h0FFFFE; bus.rw = 1'b1; bus.as_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid cs", 32'(bus.cs), 32'(one << 1));
    reset_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid idx", 32'(bus.region_idx), 0);
    bus.as_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_cycle(24'h080010, 1, 0, 0, BL, 0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
